// File: rtl/display_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | display_pkg : shared types/constants for the BCD display path   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  localparam int          BCD_DIGITS   = 8;
  localparam logic [31:0] BCD_MAX      = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT      = 32'h9999_9999;
  localparam int          SHIFT_CYCLES = 32;

  // Double-dabble correction: any digit >= 5 gets +3 before the next shift.
  function automatic logic [31:0] bcd_add3(input logic [31:0] d);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_shift_core.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_shift_core : 64-bit {digits, bin} double-dabble register    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bcd_shift_core
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_bin,
  output logic [31:0] o_digits
);

  logic [63:0] r_sr;
  logic [63:0] w_adj;

  assign w_adj = {bcd_add3(r_sr[63:32]), r_sr[31:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= {32'd0, i_bin};
    end else if (i_step) begin
      r_sr <= {w_adj[62:0], 1'b0};
    end
  end

  assign o_digits = r_sr[63:32];

endmodule
`default_nettype wire

// File: rtl/bcd_refresh_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_refresh_scheduler : round-robin BCD cache over one converter|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bcd_refresh_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int REFRESH_DIV = 100_000,
  parameter int DIGITS      = BCD_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sched_en,
  input  logic [NUM_SRC*32-1:0]       src_bin,
  output logic [NUM_SRC*DIGITS*4-1:0] bcd_out,
  output logic [NUM_SRC-1:0]          bcd_valid,
  output logic [NUM_SRC-1:0]          ovf,
  output logic                        busy,
  output logic [2:0]                  cur_src
);

  localparam int            c_res_w      = DIGITS * 4;
  localparam int            c_timer_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_timer_w-1:0] c_tick_at = c_timer_w'(REFRESH_DIV - 1);
  localparam logic [2:0]    c_last_src   = 3'(NUM_SRC - 1);
  localparam logic [4:0]    c_last_shift = 5'(SHIFT_CYCLES - 1);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [c_timer_w-1:0]          r_timer;
  logic                          w_tick;
  logic                          w_start;
  logic                          w_load;
  logic                          w_step;
  logic                          w_store;
  logic                          r_pending;
  logic [2:0]                    r_cur_src;
  logic [2:0]                    r_rr;
  logic                          r_sat;
  logic [4:0]                    r_shift_cnt;
  logic                          r_busy;
  logic [31:0]                   w_sel;
  logic [31:0]                   w_digits;
  logic [NUM_SRC*c_res_w-1:0]    r_bcd;
  logic [NUM_SRC-1:0]            r_valid;
  logic [NUM_SRC-1:0]            r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!sched_en || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_tick  = sched_en && (r_timer == c_tick_at);
  assign w_start = (r_state == ST_IDLE) && sched_en && (w_tick || r_pending);
  assign w_sel   = src_bin[int'(r_cur_src)*32 +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_shift_cnt == c_last_shift) w_state_nxt = ST_STORE;
      ST_STORE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == ST_LOAD);
    w_step  = (r_state == ST_SHIFT);
    w_store = (r_state == ST_STORE);
  end

  // A tick seen outside IDLE is remembered once; dropping sched_en forgets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= 1'b0;
      r_cur_src   <= '0;
      r_rr        <= '0;
      r_sat       <= 1'b0;
      r_shift_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (!sched_en || w_start) begin
        r_pending <= 1'b0;
      end else if (w_tick && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      if (w_start) r_cur_src <= r_rr;
      if (w_load) begin
        r_sat       <= (w_sel > BCD_MAX);
        r_shift_cnt <= '0;
      end
      if (w_step) r_shift_cnt <= r_shift_cnt + 5'd1;
      if (w_store) r_rr <= (r_cur_src == c_last_src) ? 3'd0 : r_cur_src + 3'd1;
    end
  end

  bcd_shift_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_bin    (w_sel),
    .o_digits (w_digits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
    end else if (w_store) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (r_cur_src == 3'(k)) begin
          r_bcd[k*c_res_w +: c_res_w] <= r_sat ? BCD_SAT : w_digits;
          r_valid[k]                  <= 1'b1;
          r_ovf[k]                    <= r_sat;
        end
      end
    end
  end

  assign bcd_out   = r_bcd;
  assign bcd_valid = r_valid;
  assign ovf       = r_ovf;
  assign busy      = r_busy;
  assign cur_src   = r_cur_src;

endmodule
`default_nettype wire

// File: tb/tb_bcd_refresh_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_bcd_refresh_scheduler : directed/random bench with ref model |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_bcd_refresh_scheduler;
  localparam int N    = 3;
  localparam int DIV  = 40;
  localparam int FDIV = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sched_en;
  logic [N*32-1:0] src_bin;
  logic [N*32-1:0] bcd_out;
  logic [N-1:0]    bcd_valid;
  logic [N-1:0]    ovf;
  logic            busy;
  logic [2:0]      cur_src;

  logic            sched_en_f;
  logic [N*32-1:0] src_f;
  logic [N*32-1:0] bcd_f;
  logic [N-1:0]    valid_f;
  logic [N-1:0]    ovf_f;
  logic            busy_f;
  logic [2:0]      cur_f;

  always #5 clk = ~clk;

  bcd_refresh_scheduler #(.NUM_SRC(N), .REFRESH_DIV(DIV), .DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .src_bin(src_bin),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .ovf(ovf), .busy(busy), .cur_src(cur_src)
  );

  bcd_refresh_scheduler #(.NUM_SRC(N), .REFRESH_DIV(FDIV), .DIGITS(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en_f), .src_bin(src_f),
    .bcd_out(bcd_f), .bcd_valid(valid_f), .ovf(ovf_f), .busy(busy_f), .cur_src(cur_f)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic [31:0] m_bcd [N];
  logic [N-1:0] m_valid;
  logic [N-1:0] m_ovf;
  int          m_rr;

  task automatic fail(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 99_999_999));
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_bcd[k] = '0;
    m_valid = '0;
    m_ovf   = '0;
    m_rr    = 0;
  endtask

  task automatic check_cache(input string tag);
    logic [N*32-1:0] exp_vec;
    for (int k = 0; k < N; k++) exp_vec[k*32 +: 32] = m_bcd[k];
    checks++;
    if (bcd_out !== exp_vec) fail({tag, "/bcd_out"}, bcd_out, exp_vec);
    checks++;
    if (bcd_valid !== m_valid) fail({tag, "/bcd_valid"}, bcd_valid, m_valid);
    checks++;
    if (ovf !== m_ovf) fail({tag, "/ovf"}, ovf, m_ovf);
  endtask

  task automatic conv(input int exp_gap, input int chg_at, input logic [31:0] chg_val,
                      input bit drop_en);
    int          t0;
    int          hi;
    int          s;
    logic [31:0] v;
    t0 = cyc;
    while (busy !== 1'b1 && (cyc - t0) < 300) step();
    checks++;
    if (busy !== 1'b1) fail("busy_rise", busy, 1'b1);
    if (busy !== 1'b1) return;
    if (exp_gap > 0) begin
      checks++;
      if ((cyc - last_rise) !== exp_gap) fail("tick_period", cyc - last_rise, exp_gap);
    end
    last_rise = cyc;
    checks++;
    if (cur_src !== 3'(m_rr)) fail("cur_src", cur_src, 3'(m_rr));
    s  = m_rr;
    v  = src_bin[s*32 +: 32];
    hi = 0;
    while (busy === 1'b1 && hi < 60) begin
      hi++;
      if (hi == chg_at) src_bin[s*32 +: 32] = chg_val;
      if (drop_en && hi == 11) sched_en = 1'b0;
      step();
    end
    checks++;
    if (hi !== 34) fail("busy_len", hi, 34);
    m_bcd[s]   = ref_bcd(v);
    m_ovf[s]   = (v > 32'd99_999_999);
    m_valid[s] = 1'b1;
    m_rr       = (s + 1) % N;
    check_cache("conv");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq0 [3];
    logic        seq_ovf [3];
    int          rises;
    int          low_gap;
    int          drop_at;
    bit          prev;
    bit          seen_fall;
    logic [31:0] exp0;

    rst_n      = 1'b0;
    sched_en   = 1'b1;
    sched_en_f = 1'b0;
    src_bin    = {32'd99_999_999, 32'd0, 32'd12345};
    src_f      = {rnd_val(), rnd_val(), rnd_val()};
    model_reset();
    repeat (3) step();

    checks++;
    if (bcd_out !== 96'd0) fail("rst/bcd_out", bcd_out, 96'd0);
    checks++;
    if (bcd_valid !== 3'b000) fail("rst/bcd_valid", bcd_valid, 3'b000);
    checks++;
    if (ovf !== 3'b000) fail("rst/ovf", ovf, 3'b000);
    checks++;
    if (busy !== 1'b0) fail("rst/busy", busy, 1'b0);
    checks++;
    if (cur_src !== 3'd0) fail("rst/cur_src", cur_src, 3'd0);

    rst_n     = 1'b1;
    last_rise = cyc;
    repeat (3) conv(DIV, 0, 32'd0, 1'b0);
    checks++;
    if (bcd_out !== {32'h9999_9999, 32'h0, 32'h0001_2345})
      fail("plan/bcd_out", bcd_out, {32'h9999_9999, 32'h0, 32'h0001_2345});
    checks++;
    if (bcd_valid !== 3'b111) fail("plan/valid", bcd_valid, 3'b111);
    checks++;
    if (ovf !== 3'b000) fail("plan/ovf", ovf, 3'b000);

    seq0[0] = 32'd100_000_000; seq_ovf[0] = 1'b1;
    seq0[1] = 32'hFFFF_FFFF;   seq_ovf[1] = 1'b1;
    seq0[2] = 32'd7;           seq_ovf[2] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      src_bin[31:0] = seq0[r];
      conv(DIV, 0, 32'd0, 1'b0);
      checks++;
      if (ovf[0] !== seq_ovf[r]) fail("sat/ovf0", ovf[0], seq_ovf[r]);
      exp0 = seq_ovf[r] ? 32'h9999_9999 : 32'h0000_0007;
      checks++;
      if (bcd_out[31:0] !== exp0) fail("sat/bcd0", bcd_out[31:0], exp0);
      src_bin[95:32] = {rnd_val(), rnd_val()};
      repeat (2) conv(DIV, 0, 32'd0, 1'b0);
    end

    src_bin[31:0] = 32'd555;
    conv(DIV, 15, 32'd999, 1'b0);
    checks++;
    if (bcd_out[31:0] !== 32'h0000_0555) fail("snap/first", bcd_out[31:0], 32'h0000_0555);
    src_bin[95:32] = {rnd_val(), rnd_val()};
    repeat (2) conv(DIV, 0, 32'd0, 1'b0);
    conv(DIV, 0, 32'd0, 1'b0);
    checks++;
    if (bcd_out[31:0] !== 32'h0000_0999) fail("snap/second", bcd_out[31:0], 32'h0000_0999);

    src_bin[63:32] = rnd_val();
    conv(DIV, 0, 32'd0, 1'b1);
    rises = 0;
    prev  = busy;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy && !prev) rises++;
      prev = busy;
    end
    checks++;
    if (rises !== 0) fail("disable/no_load", rises, 0);
    sched_en  = 1'b1;
    last_rise = cyc;
    conv(DIV, 0, 32'd0, 1'b0);

    src_bin = {rnd_val(), rnd_val(), rnd_val()};
    conv(DIV, 0, 32'd0, 1'b0);
    t_reset_mid: begin
      int t0;
      t0 = cyc;
      while (busy !== 1'b1 && (cyc - t0) < 300) step();
      checks++;
      if (busy !== 1'b1) fail("arst/busy_rise", busy, 1'b1);
      repeat (10) step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bcd_out !== 96'd0) fail("arst/bcd_out", bcd_out, 96'd0);
      checks++;
      if (bcd_valid !== 3'b000) fail("arst/valid", bcd_valid, 3'b000);
      checks++;
      if (ovf !== 3'b000) fail("arst/ovf", ovf, 3'b000);
      checks++;
      if (busy !== 1'b0) fail("arst/busy", busy, 1'b0);
      checks++;
      if (cur_src !== 3'd0) fail("arst/cur_src", cur_src, 3'd0);
      step();
      step();
      model_reset();
      rst_n     = 1'b1;
      last_rise = cyc;
    end
    conv(DIV, 0, 32'd0, 1'b0);
    conv(DIV, 0, 32'd0, 1'b0);

    sched_en_f = 1'b1;
    rises      = 0;
    low_gap    = 0;
    drop_at    = -1;
    prev       = busy_f;
    seen_fall  = 1'b0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (busy_f && !prev) begin
        rises++;
        if (rises == 2) drop_at = i + 5;
      end
      if (!busy_f && prev && rises == 1) seen_fall = 1'b1;
      if (!busy_f && seen_fall && rises == 1) low_gap++;
      if (i == drop_at) sched_en_f = 1'b0;
      prev = busy_f;
    end
    checks++;
    if (rises !== 2) fail("pend/conversions", rises, 2);
    checks++;
    if ((low_gap >= 1 && low_gap <= 2) !== 1'b1) fail("pend/idle_gap_ok", low_gap, 1);
    checks++;
    if (valid_f !== 3'b011) fail("pend/valid", valid_f, 3'b011);
    checks++;
    if (cur_f !== 3'd1) fail("pend/cur_src", cur_f, 3'd1);
    checks++;
    if (bcd_f[31:0] !== ref_bcd(src_f[31:0])) fail("pend/bcd0", bcd_f[31:0], ref_bcd(src_f[31:0]));
    checks++;
    if (bcd_f[63:32] !== ref_bcd(src_f[63:32])) fail("pend/bcd1", bcd_f[63:32], ref_bcd(src_f[63:32]));
    checks++;
    if (bcd_f[95:64] !== 32'h0) fail("pend/bcd2", bcd_f[95:64], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
